// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic PE array: takes one N-lane column per beat and
// drives the array edge with lane i delayed i cycles, then flushes and flags frame end.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_valid,
  output logic            busy,
  output logic            frame_done
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nx_s;
  logic            frame_done_r;
  logic            frame_done_nx_s;
  logic            accept_s;

  assign in_ready   = (state_r != FLUSH);
  assign busy       = (state_r != IDLE);
  assign frame_done = frame_done_r;
  assign accept_s   = in_valid && in_ready;

  // Control state, flush counter and frame_done pulse register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      frame_done_r <= frame_done_nx_s;
    end
  end

  // Next-state logic; the flush count is sized so done lands as lane N-1 shows the last element.
  always_comb begin
    state_nx_s      = state_r;
    cnt_nx_s        = cnt_r;
    frame_done_nx_s = 1'b0;
    case (state_r)
      IDLE, STREAM: begin
        if (accept_s && in_last) begin
          state_nx_s = FLUSH;
          cnt_nx_s   = CW'(N - 1);
        end else if (accept_s) begin
          state_nx_s = STREAM;
        end else begin
          state_nx_s = state_r;
        end
      end
      FLUSH: begin
        if (cnt_r == CW'(1)) begin
          state_nx_s      = IDLE;
          cnt_nx_s        = {CW{1'b0}};
          frame_done_nx_s = 1'b1;
        end else begin
          cnt_nx_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CW{1'b0}};
      end
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    // Stage 0 is this lane's slice of the common input register; stages 1..i form the skew.
    logic [DW-1:0] d_r [i+1];
    logic [i:0]    v_r;

    // Free-running delay line; idle cycles shift in zero bubbles to keep lanes aligned.
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int k = 0; k <= i; k++) begin
          d_r[k] <= {DW{1'b0}};
        end
        v_r <= {(i+1){1'b0}};
      end else begin
        d_r[0] <= accept_s ? in_data[i*DW +: DW] : {DW{1'b0}};
        v_r[0] <= accept_s;
        for (int k = 1; k <= i; k++) begin
          d_r[k] <= d_r[k-1];
          v_r[k] <= v_r[k-1];
        end
      end
    end

    assign out_data[i*DW +: DW] = d_r[i];
    assign out_valid[i]         = v_r[i];
  end

endmodule
